counter_trig_sched: RTL and testbench

Command-driven trigger scheduler for a bank of COUNTER_NUM counter instances. Software or another master posts one command: op, counter mask, initial delay, repeat count and period. The block then issues precisely timed one-cycle start/stop/clear/reset pulses, either per counter on the single trigger inputs or on the bank-wide global trigger inputs. It sits between the register interface and the counter array and replaces ad-hoc software pulsing of trigger bits.

---
 rtl/counter_pkg.sv | 22 ++
 rtl/counter_sched_timer.sv | 37 +++
 rtl/counter_trig_sched.sv | 178 +++++++++++++++++
 tb/tb_counter_trig_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared op/state encodings and default widths for the trigger scheduler
package counter_pkg;

  localparam int DEF_COUNTER_NUM = 4;
  localparam int DEF_DLY_W       = 16;
  localparam int DEF_REP_W       = 8;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RESET = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_FIRE   = 2'd2,
    ST_PERIOD = 2'd3
  } state_e;

endpackage

// File: rtl/counter_sched_timer.sv
// rtl/counter_sched_timer.sv - loadable down-counter shared by delay and period countdowns
module counter_sched_timer
  import counter_pkg::*;
#(
  parameter int DLY_W = DEF_DLY_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [DLY_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_last
);

  logic [DLY_W-1:0] value_q, value_d;

  // Saturates at zero so a stray enable after the last cycle cannot wrap.
  always_comb begin
    value_d = value_q;
    if (i_load) begin
      value_d = i_load_val;
    end else if (i_en && (value_q != '0)) begin
      value_d = value_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign o_last = (value_q == DLY_W'(1));

endmodule

// File: rtl/counter_trig_sched.sv
// rtl/counter_trig_sched.sv - command-driven scheduler issuing timed trigger pulses to a counter bank
module counter_trig_sched
  import counter_pkg::*;
#(
  parameter int COUNTER_NUM = DEF_COUNTER_NUM,
  parameter int DLY_W       = DEF_DLY_W,
  parameter int REP_W       = DEF_REP_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [1:0]             i_cmd_op,
  input  logic                   i_cmd_global,
  input  logic [COUNTER_NUM-1:0] i_cmd_mask,
  input  logic [DLY_W-1:0]       i_cmd_delay,
  input  logic [REP_W-1:0]       i_cmd_repeat,
  input  logic [DLY_W-1:0]       i_cmd_period,
  input  logic                   i_abort,
  output logic [COUNTER_NUM-1:0] o_single_start_trigger,
  output logic [COUNTER_NUM-1:0] o_single_stop_trigger,
  output logic [COUNTER_NUM-1:0] o_single_clear_trigger,
  output logic [COUNTER_NUM-1:0] o_single_reset_trigger,
  output logic                   o_global_start_trigger,
  output logic                   o_global_stop_trigger,
  output logic                   o_global_clear_trigger,
  output logic                   o_global_reset_trigger,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_aborted,
  output logic [REP_W-1:0]       o_rep_left
);

  state_e                        state_q, state_d;
  op_e                           op_q, op_d;
  logic                          glob_q, glob_d;
  logic [COUNTER_NUM-1:0]        mask_q, mask_d;
  logic [DLY_W-1:0]              period_q, period_d;
  logic [REP_W-1:0]              rep_q, rep_d;
  logic                          done_q, done_d;
  logic                          aborted_q, aborted_d;
  logic [3:0][COUNTER_NUM-1:0]   single_q, single_d;
  logic [3:0]                    gtrig_q, gtrig_d;
  logic                          fire_next;
  logic                          tmr_load, tmr_en, tmr_last;
  logic [DLY_W-1:0]              tmr_load_val;

  counter_sched_timer #(.DLY_W(DLY_W)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_load_val),
    .i_en       (tmr_en),
    .o_last     (tmr_last)
  );

  assign o_cmd_ready = (state_q == ST_IDLE) && !i_abort;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    glob_d       = glob_q;
    mask_d       = mask_q;
    period_d     = period_q;
    rep_d        = rep_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    fire_next    = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;
    single_d     = '0;
    gtrig_d      = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          op_d     = op_e'(i_cmd_op);
          glob_d   = i_cmd_global;
          mask_d   = i_cmd_mask;
          period_d = i_cmd_period;
          rep_d    = i_cmd_repeat;
          if (i_cmd_delay == '0) begin
            state_d   = ST_FIRE;
            fire_next = 1'b1;
          end else begin
            state_d      = ST_DELAY;
            tmr_load     = 1'b1;
            tmr_load_val = i_cmd_delay;
          end
        end
      end
      ST_DELAY, ST_PERIOD: begin
        if (i_abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          rep_d     = '0;
        end else begin
          tmr_en = 1'b1;
          if (tmr_last) begin
            state_d   = ST_FIRE;
            fire_next = 1'b1;
          end
        end
      end
      ST_FIRE: begin
        if (i_abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          rep_d     = '0;
        end else if (rep_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          rep_d = rep_q - 1'b1;
          if (period_q == '0) begin
            state_d   = ST_FIRE;
            fire_next = 1'b1;
          end else begin
            state_d      = ST_PERIOD;
            tmr_load     = 1'b1;
            tmr_load_val = period_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Trigger flops are loaded one cycle early so they are high exactly in FIRE.
    if (fire_next) begin
      if (glob_d) begin
        gtrig_d[op_d] = 1'b1;
      end else begin
        single_d[op_d] = mask_d;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_START;
      glob_q    <= 1'b0;
      mask_q    <= '0;
      period_q  <= '0;
      rep_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      single_q  <= '0;
      gtrig_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      glob_q    <= glob_d;
      mask_q    <= mask_d;
      period_q  <= period_d;
      rep_q     <= rep_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      single_q  <= single_d;
      gtrig_q   <= gtrig_d;
    end
  end

  assign o_single_start_trigger = single_q[OP_START];
  assign o_single_stop_trigger  = single_q[OP_STOP];
  assign o_single_clear_trigger = single_q[OP_CLEAR];
  assign o_single_reset_trigger = single_q[OP_RESET];
  assign o_global_start_trigger = gtrig_q[OP_START];
  assign o_global_stop_trigger  = gtrig_q[OP_STOP];
  assign o_global_clear_trigger = gtrig_q[OP_CLEAR];
  assign o_global_reset_trigger = gtrig_q[OP_RESET];
  assign o_busy                 = (state_q != ST_IDLE);
  assign o_done                 = done_q;
  assign o_aborted              = aborted_q;
  assign o_rep_left             = rep_q;

endmodule

// File: tb/tb_counter_trig_sched.sv
// tb/tb_counter_trig_sched.sv - scoreboard bench for counter_trig_sched
module tb_counter_trig_sched;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_op = 2'd0;
  logic        i_cmd_global = 1'b0;
  logic [3:0]  i_cmd_mask = 4'd0;
  logic [15:0] i_cmd_delay = 16'd0;
  logic [7:0]  i_cmd_repeat = 8'd0;
  logic [15:0] i_cmd_period = 16'd0;
  logic        i_abort = 1'b0;
  logic [3:0]  ss_start, ss_stop, ss_clear, ss_reset;
  logic        gs_start, gs_stop, gs_clear, gs_reset;
  logic        o_busy, o_done, o_aborted;
  logic [7:0]  o_rep_left;

  counter_trig_sched dut (
    .i_clk                  (i_clk),
    .i_rst                  (i_rst),
    .i_cmd_valid            (i_cmd_valid),
    .o_cmd_ready            (o_cmd_ready),
    .i_cmd_op               (i_cmd_op),
    .i_cmd_global           (i_cmd_global),
    .i_cmd_mask             (i_cmd_mask),
    .i_cmd_delay            (i_cmd_delay),
    .i_cmd_repeat           (i_cmd_repeat),
    .i_cmd_period           (i_cmd_period),
    .i_abort                (i_abort),
    .o_single_start_trigger (ss_start),
    .o_single_stop_trigger  (ss_stop),
    .o_single_clear_trigger (ss_clear),
    .o_single_reset_trigger (ss_reset),
    .o_global_start_trigger (gs_start),
    .o_global_stop_trigger  (gs_stop),
    .o_global_clear_trigger (gs_clear),
    .o_global_reset_trigger (gs_reset),
    .o_busy                 (o_busy),
    .o_done                 (o_done),
    .o_aborted              (o_aborted),
    .o_rep_left             (o_rep_left)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [29:0] v;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Observation layout: {aborted, done, global[reset..start], single reset/clear/stop/start, rep_left}
  logic [29:0] obs;
  assign obs = {o_aborted, o_done, gs_reset, gs_clear, gs_stop, gs_start,
                ss_reset, ss_clear, ss_stop, ss_start, o_rep_left};

  function automatic logic [29:0] trig_v(input logic [1:0] op, input logic glob,
                                         input logic [3:0] mask, input logic [7:0] rep);
    logic [3:0]  g;
    logic [15:0] s;
    g = '0;
    s = '0;
    if (glob) g[op] = 1'b1;
    else s[op*4 +: 4] = mask;
    return {2'b00, g, s, rep};
  endfunction

  localparam logic [29:0] DONE_V  = {2'b01, 28'd0};
  localparam logic [29:0] ABORT_V = {2'b10, 28'd0};

  task automatic push(input int c, input logic [29:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: any pulse-bearing cycle must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst && (obs[29:8] != '0)) begin
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got %0h at cycle %0d, expected nothing", obs, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.v !== obs) begin
          n_bad++;
          $display("FAIL pulse: got %0h at cycle %0d expected %0h at cycle %0d", obs, cyc, e.v, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic glob, input logic [3:0] mask,
                       input logic [15:0] dly, input logic [7:0] rep, input logic [15:0] per,
                       output int t);
    @(negedge i_clk);
    i_cmd_op = op; i_cmd_global = glob; i_cmd_mask = mask;
    i_cmd_delay = dly; i_cmd_repeat = rep; i_cmd_period = per;
    i_cmd_valid = 1'b1;
    t = -1;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (o_cmd_ready) begin
        t = cyc;
        break;
      end
      @(negedge i_clk);
    end
    if (t < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got no ready expected ready within 200 cycles");
    end
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
    i_cmd_mask  = 4'hF;
    i_cmd_delay = 16'd0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge i_clk);
      #1;
      if (!o_busy && q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle and empty", o_busy, q.size());
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic wait_cyc(input int c);
    for (int k = 0; k < 300 && cyc < c; k++) @(negedge i_clk);
  endtask

  initial begin
    int t, t2;
    repeat (3) @(negedge i_clk);
    #1;
    chk("reset_outputs", {2'b0, o_busy, obs}, 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    #1;
    chk("reset_ready", o_cmd_ready, 1);

    // Single start, mask 0101, delay 3
    issue(2'd0, 1'b0, 4'b0101, 16'd3, 8'd0, 16'd0, t);
    push(t + 4, trig_v(2'd0, 1'b0, 4'b0101, 8'd0));
    push(t + 5, DONE_V);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      chk($sformatf("busy_T+%0d", k + 1), o_busy, (k < 4) ? 1 : 0);
    end
    wait_idle();

    // Global clear, delay 0, repeat 2, period 1; single mask must stay dark
    issue(2'd2, 1'b1, 4'b1111, 16'd0, 8'd2, 16'd1, t);
    push(t + 1, trig_v(2'd2, 1'b1, 4'b0, 8'd2));
    push(t + 3, trig_v(2'd2, 1'b1, 4'b0, 8'd1));
    push(t + 5, trig_v(2'd2, 1'b1, 4'b0, 8'd0));
    push(t + 6, DONE_V);
    wait_idle();

    // Back-to-back stop pulses, then a mask=0 reset accepted in the done cycle
    issue(2'd1, 1'b0, 4'b1111, 16'd0, 8'd3, 16'd0, t);
    push(t + 1, trig_v(2'd1, 1'b0, 4'b1111, 8'd3));
    push(t + 2, trig_v(2'd1, 1'b0, 4'b1111, 8'd2));
    push(t + 3, trig_v(2'd1, 1'b0, 4'b1111, 8'd1));
    push(t + 4, trig_v(2'd1, 1'b0, 4'b1111, 8'd0));
    push(t + 5, DONE_V);
    issue(2'd3, 1'b0, 4'b0000, 16'd2, 8'd0, 16'd0, t2);
    chk("b2b_accept_cycle", t2, t + 5);
    push(t2 + 4, DONE_V);
    wait_idle();

    // Abort in IDLE blocks ready
    @(negedge i_clk);
    i_abort = 1'b1;
    #1;
    chk("ready_abort_idle", o_cmd_ready, 0);
    @(negedge i_clk);
    i_abort = 1'b0;

    // Abort during a long delay
    issue(2'd0, 1'b0, 4'b0011, 16'd10, 8'd4, 16'd0, t);
    wait_cyc(t + 5);
    i_abort = 1'b1;
    push(t + 6, ABORT_V);
    #1;
    chk("ready_abort_delay", o_cmd_ready, 0);
    chk("rep_before_abort", o_rep_left, 8'd4);
    @(posedge i_clk);
    #1;
    i_abort = 1'b0;
    @(negedge i_clk);
    chk("busy_after_abort", o_busy, 0);
    chk("rep_after_abort", o_rep_left, 8'd0);
    repeat (15) @(negedge i_clk);
    chk("abort_queue_drained", q.size(), 0);

    // Async reset mid-PERIOD
    issue(2'd2, 1'b0, 4'b1000, 16'd0, 8'd5, 16'd4, t);
    push(t + 1, trig_v(2'd2, 1'b0, 4'b1000, 8'd5));
    wait_cyc(t + 3);
    chk("busy_mid_period", o_busy, 1);
    i_rst = 1'b1;
    #1;
    chk("reset_mid_outputs", {2'b0, o_busy, obs}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("ready_after_reset", o_cmd_ready, 1);
    repeat (15) @(negedge i_clk);
    chk("busy_after_reset", o_busy, 0);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL missing_pulse: got nothing expected %0h at cycle %0d", e.v, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1);
  end

endmodule
